// File: rtl/cam_fb_pkg.sv
// Shared types and RGB565 field helpers for the camera frame-buffer writer.
package cam_fb_pkg;

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        WAIT   = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    // RGB565 arrives high byte first: RRRRRGGG then GGGBBBBB.
    localparam int R_HI_MSB = 7;
    localparam int R_HI_LSB = 3;
    localparam int G_HI_MSB = 2;
    localparam int G_LO_LSB = 5;
    localparam int B_LO_MSB = 4;

    function automatic logic [3:0] rgb565_to_gray4(input logic [7:0] hi, input logic [7:0] lo);
        logic [4:0] r5;
        logic [4:0] b5;
        logic [5:0] g6;
        logic [5:0] r6;
        logic [5:0] b6;
        logic [7:0] sum;
        r5  = hi[R_HI_MSB:R_HI_LSB];
        g6  = {hi[G_HI_MSB:0], lo[7:G_LO_LSB]};
        b5  = lo[B_LO_MSB:0];
        r6  = {r5, r5[4]};
        b6  = {b5, b5[4]};
        sum = {2'b00, r6} + {1'b0, g6, 1'b0} + {2'b00, b6};
        return sum[7:4];
    endfunction

endpackage

// File: rtl/cam_line_counter.sv
// Pixel/line position tracking and frame-buffer limit checks.
// Build option CAM_FB_DECIMATE_EN: only even pixels of even source lines are write candidates.
module cam_line_counter
    import cam_fb_pkg::*;
#(
    parameter int H_RES  = 320,
    parameter int V_RES  = 240,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              pixel,
    input  logic              line_end,
    output logic              wr_ok,
    output logic [ADDR_W-1:0] addr,
    output logic              frame_full
);

    localparam int X_W = $clog2(H_RES + 1);
    localparam int Y_W = $clog2(V_RES + 1);
    localparam logic [X_W-1:0]    X_MAX     = X_W'(H_RES);
    localparam logic [Y_W-1:0]    Y_MAX     = Y_W'(V_RES);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_RES);

    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic [ADDR_W-1:0] line_base;
    logic              cand;
    logic              adv_line;

`ifdef CAM_FB_DECIMATE_EN
    logic sx;
    logic sy;

    assign cand       = !sx && !sy;
    assign adv_line   = !sy;
    assign frame_full = (y == Y_MAX) && !sy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sx <= 1'b0;
            sy <= 1'b0;
        end else if (clear) begin
            sx <= 1'b0;
            sy <= 1'b0;
        end else if (line_end) begin
            sx <= 1'b0;
            sy <= !sy;
        end else if (pixel) begin
            sx <= !sx;
        end
    end
`else
    assign cand       = 1'b1;
    assign adv_line   = 1'b1;
    assign frame_full = (y == Y_MAX);
`endif

    assign wr_ok = cand && (x < X_MAX) && (y < Y_MAX);
    assign addr  = line_base + ADDR_W'(x);

    // y stops at V_RES so surplus lines neither write nor wrap the counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x         <= '0;
            y         <= '0;
            line_base <= '0;
        end else if (clear) begin
            x         <= '0;
            y         <= '0;
            line_base <= '0;
        end else if (line_end) begin
            x <= '0;
            if (adv_line && (y < Y_MAX)) begin
                y         <= y + 1'b1;
                line_base <= line_base + LINE_STEP;
            end
        end else if (pixel && cand && (x < X_MAX)) begin
            x <= x + 1'b1;
        end
    end

endmodule

// File: rtl/cam_fb_writer.sv
// Camera parallel-bus capture: RGB565 byte pairs -> 4-bit grey writes into the frame buffer.
// Build option CAM_FB_DECIMATE_EN: 2x downscale of a 2*H_RES x 2*V_RES source.
module cam_fb_writer
    import cam_fb_pkg::*;
#(
    parameter int H_RES  = 320,
    parameter int V_RES  = 240,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        data,
    output logic              we,
    output logic [ADDR_W-1:0] wAddr,
    output logic [3:0]        wData,
    output logic              frame_done,
    output logic              busy
);

    state_t            state;
    logic              vsync_q;
    logic              href_q;
    logic              phase;
    logic [7:0]        hi;
    logic              vs_rise;
    logic              href_fall;
    logic              byte_ok;
    logic              clear;
    logic              pixel;
    logic              line_end;
    logic              wr_ok;
    logic              frame_full;
    logic [ADDR_W-1:0] addr;

    assign vs_rise   = vsync && !vsync_q;
    assign href_fall = href_q && !href;
    // vsync takes priority over any byte or line edge in the same cycle.
    assign byte_ok   = (state == ACTIVE) && href && !vsync;
    assign clear     = (state == WAIT) && !vsync;
    assign pixel     = byte_ok && phase;
    assign line_end  = (state == ACTIVE) && !vsync && href_fall;
    assign busy      = (state == ACTIVE);

    cam_line_counter #(
        .H_RES (H_RES),
        .V_RES (V_RES),
        .ADDR_W(ADDR_W)
    ) u_lines (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear),
        .pixel     (pixel),
        .line_end  (line_end),
        .wr_ok     (wr_ok),
        .addr      (addr),
        .frame_full(frame_full)
    );

    always_ff @(posedge clk) begin
        if (byte_ok && !phase) begin
            hi <= data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= SYNC;
            vsync_q    <= 1'b0;
            href_q     <= 1'b0;
            phase      <= 1'b0;
            we         <= 1'b0;
            wAddr      <= '0;
            wData      <= '0;
            frame_done <= 1'b0;
        end else begin
            vsync_q    <= vsync;
            href_q     <= href;
            we         <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                SYNC: begin
                    if (vs_rise) state <= WAIT;
                end
                WAIT: begin
                    if (!vsync) begin
                        state <= ACTIVE;
                        phase <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (vs_rise) begin
                        state      <= WAIT;
                        phase      <= 1'b0;
                        frame_done <= frame_full;
                    end else if (byte_ok) begin
                        phase <= !phase;
                        if (phase) begin
                            we <= wr_ok;
                            if (wr_ok) begin
                                wAddr <= addr;
                                wData <= rgb565_to_gray4(hi, data);
                            end
                        end
                    end else if (line_end) begin
                        phase <= 1'b0;
                    end
                end
                default: state <= SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_cam_fb_writer.sv
// Scoreboard bench for cam_fb_writer on a reduced 16x8 frame buffer.
module tb_cam_fb_writer;

    localparam int H = 16;
    localparam int V = 8;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic [3:0]  dat;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        vsync;
    logic        href;
    logic [7:0]  data;
    logic        we;
    logic [31:0] wAddr;
    logic [3:0]  wData;
    logic        frame_done;
    logic        busy;

    wr_t exp_q[$];
    int  cyc        = 0;
    int  ln         = 0;
    int  fd_pending = 0;
    int  n_checks   = 0;
    int  n_fail     = 0;

    cam_fb_writer #(.H_RES(H), .V_RES(V), .ADDR_W(32)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .vsync     (vsync),
        .href      (href),
        .data      (data),
        .we        (we),
        .wAddr     (wAddr),
        .wData     (wData),
        .frame_done(frame_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Monitor: every write and frame_done pulse is matched against the scoreboard.
    always @(negedge clk) begin
        if (reset_n) begin
            if (we) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL write_unexpected cyc=%0d addr=%0d data=%h", cyc, wAddr, wData);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    if (cyc != e.cyc || wAddr !== e.addr || wData !== e.dat) begin
                        n_fail++;
                        $display("FAIL write actual cyc=%0d addr=%0d data=%h expected cyc=%0d addr=%0d data=%h",
                                 cyc, wAddr, wData, e.cyc, e.addr, e.dat);
                    end
                end
            end
            if (frame_done) begin
                n_checks++;
                if (fd_pending > 0) fd_pending--;
                else begin
                    n_fail++;
                    $display("FAIL frame_done_unexpected actual=1 expected=0 cyc=%0d", cyc);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic h, input logic v, input logic [7:0] d);
        @(negedge clk);
        href  = h;
        vsync = v;
        data  = d;
    endtask

    task automatic send_line(input int npix, input logic [15:0] px, input logic [3:0] g, input bit odd);
        int a;
        bit wr;
        for (int p = 0; p < npix; p++) begin
            drive(1'b1, 1'b0, px[15:8]);
            drive(1'b1, 1'b0, px[7:0]);
`ifdef CAM_FB_DECIMATE_EN
            wr = (p % 2 == 0) && (ln % 2 == 0) && (p / 2 < H) && (ln / 2 < V);
            a  = (ln / 2) * H + p / 2;
`else
            wr = (p < H) && (ln < V);
            a  = ln * H + p;
`endif
            if (wr) exp_q.push_back('{cyc + 1, 32'(a), g});
        end
        if (odd) drive(1'b1, 1'b0, 8'hA5);
        repeat (4) drive(1'b0, 1'b0, 8'h00);
        ln++;
    endtask

    task automatic end_frame(input bit fd);
        if (fd) fd_pending++;
        drive(1'b0, 1'b1, 8'h00);
        drive(1'b0, 1'b1, 8'h00);
        check("busy_in_wait", 64'(busy), 64'd0);
        drive(1'b0, 1'b1, 8'h00);
        check("frame_done_count", 64'(fd_pending), 64'd0);
        check("writes_drained", 64'(exp_q.size()), 64'd0);
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
        check("busy_active", 64'(busy), 64'd1);
        ln = 0;
    endtask

    initial begin
        reset_n = 1'b0;
        vsync   = 1'b0;
        href    = 1'b0;
        data    = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_we", 64'(we), 64'd0);
        check("rst_waddr", 64'(wAddr), 64'd0);
        check("rst_wdata", 64'(wData), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

`ifdef CAM_FB_DECIMATE_EN
        end_frame(1'b0);
        for (int l = 0; l < 2 * V; l++) send_line(2 * H, 16'hFFFF, 4'hF, 1'b0);
        end_frame(1'b1);
`else
        // Full frame of white.
        end_frame(1'b0);
        for (int l = 0; l < V; l++) send_line(H, 16'hFFFF, 4'hF, 1'b0);
        end_frame(1'b1);

        // Short frame: colour decode, overlong line, odd-byte burst; no frame_done.
        send_line(H, 16'hF800, 4'h3, 1'b0);
        send_line(H, 16'h07E0, 4'h7, 1'b0);
        send_line(H, 16'h0000, 4'h0, 1'b0);
        send_line(H, 16'h1234, 4'h4, 1'b0);
        send_line(H + 10, 16'hFFFF, 4'hF, 1'b0);
        send_line(3, 16'h07E0, 4'h7, 1'b1);
        send_line(H, 16'hF800, 4'h3, 1'b0);
        end_frame(1'b0);

        // Next full frame restarts at address 0.
        for (int l = 0; l < V; l++) send_line(H, 16'hF800, 4'h3, 1'b0);
        end_frame(1'b1);

        // Reset in the middle of a pixel pair drops that pixel.
        drive(1'b1, 1'b0, 8'h07);
        drive(1'b1, 1'b0, 8'hE0);
        exp_q.push_back('{cyc + 1, 32'd0, 4'h7});
        drive(1'b1, 1'b0, 8'h07);
        drive(1'b1, 1'b0, 8'hE0);
        exp_q.push_back('{cyc + 1, 32'd1, 4'h7});
        drive(1'b1, 1'b0, 8'h07);
        @(negedge clk);
        data    = 8'hE0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_we", 64'(we), 64'd0);
        check("midrst_waddr", 64'(wAddr), 64'd0);
        check("midrst_wdata", 64'(wData), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_frame_done", 64'(frame_done), 64'd0);
        check("midrst_drained", 64'(exp_q.size()), 64'd0);
        reset_n = 1'b1;
        href    = 1'b0;
        repeat (6) drive(1'b1, 1'b0, 8'h5A);
        repeat (3) drive(1'b0, 1'b0, 8'h00);
        check("sync_idle_busy", 64'(busy), 64'd0);

        end_frame(1'b0);
        for (int l = 0; l < V; l++) send_line(H, 16'hFFFF, 4'hF, 1'b0);
        end_frame(1'b1);
`endif

        repeat (4) @(negedge clk);
        check("final_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cam_fb_writer.md
Name: cam_fb_writer

Overview:
- Write-side producer for the 4-bit 320x240 frame buffer. Runs on the camera pixel clock.
- Captures RGB565 byte pairs from the camera parallel bus (vsync/href/data) and converts each pair to 4-bit grey.
- Drives the buffer's we/wAddr/wData port with a linear row-major address.
- Emits a one-cycle frame_done pulse at the end of every complete frame.

Parameters:
- H_RES, 320, pixels written per line; later pixels in a line are dropped.
- V_RES, 240, lines written per frame; later lines are dropped.
- ADDR_W, 32, width of wAddr.

Ports:
- clk  in  1  camera pixel clock; all logic samples on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- vsync  in  1  camera frame sync, active high.
- href  in  1  camera line valid, active high.
- data  in  8  camera byte bus.
- we  out  1  frame-buffer write enable.
- wAddr  out  ADDR_W  frame-buffer write address.
- wData  out  4  grey pixel.
- frame_done  out  1  one-cycle pulse when a frame completes.
- busy  out  1  high in ACTIVE state.

Behaviour:
- Reset values: all outputs 0, FSM in SYNC, all counters 0, byte phase 0.
- Inputs are sampled directly on clk with no synchroniser; they are source-synchronous to clk.
- FSM states:
  - SYNC (after reset): wait for a vsync rising edge, then go to WAIT.
  - WAIT: on vsync low, go to ACTIVE; clear x, y, line_base, phase.
  - ACTIVE:
    - href high: byte phase toggles every cycle. Phase 0 latches hi = data. Phase 1 forms the pixel from hi and data.
    - href falling edge: y += 1, line_base += H_RES, x = 0, phase = 0. A dangling odd byte is discarded.
    - vsync rising edge: go to WAIT. Pulse frame_done only if y == V_RES; otherwise the frame is a short frame and there is no pulse.
    - href and vsync both high in the same cycle: vsync wins, and the byte is ignored.
- Pixel decode:
  - R5 = hi[7:3]; G6 = {hi[2:0], data[7:5]}; B5 = data[4:0].
  - R6 = {R5, R5[4]}; B6 = {B5, B5[4]}.
  - sum = R6 + 2*G6 + B6, computed 8-bit unsigned, maximum 252.
  - wData = sum[7:4].
- Write rules:
  - A write occurs only if x < H_RES and y < V_RES. Then wAddr = line_base + x, and x increments after the write.
  - Pixels beyond the limits produce no write; x saturates at H_RES.
  - Outputs are registered. we is high exactly the cycle after the phase-1 byte is sampled, for one cycle.
- frame_done is registered and high for one cycle. busy = (state == ACTIVE).
- Reset asserted mid-line: immediate return to the reset state, and no write is emitted.

Optional Feature:
- Macro CAM_FB_DECIMATE_EN.
- Defined: the camera runs at 2*H_RES x 2*V_RES. Only even source pixels of even source lines are written; the other pixels are decoded but suppressed. y and line_base advance only on even-to-odd line transitions, so the output address is identical to native mode. frame_done requires 2*V_RES source lines.
- Undefined: every pixel and every line is a write candidate, as described above.

Decomposition:
- Package cam_fb_pkg:
  - state enum {SYNC, WAIT, ACTIVE};
  - RGB565 field-position constants;
  - function rgb565_to_gray4(hi, lo).
- Sub-module cam_line_counter: owns x, y, line_base and the limit compares. The FSM and decode stay in the top module.

Test Plan:
- Reset then one full 320x240 frame with every pair = 0xFFFF -> 76800 writes, wData = 0xF, last wAddr = 76799, exactly one frame_done.
- Pair 0xF800 (pure red) -> wData = 0x3; pair 0x07E0 (pure green) -> wData = 0x7; pair 0x0000 -> 0x0. Each write lands 1 cycle after the second byte.
- Line of 330 pixels -> only x = 0..319 written for that line; next line starts at wAddr = 320*(y+1).
- 7-byte href burst on line 5 -> 3 writes at addrs 1600..1602; odd byte dropped; next line base is 1920.
- vsync rising after 100 lines -> no frame_done; next full frame restarts at wAddr 0.
- With CAM_FB_DECIMATE_EN: 640x480 frame -> 76800 writes, addresses 0..76799 contiguous, one frame_done.
